// File: rtl/ifetch_if.sv
// Fetch-stage bus: ROM address/data, the decode-side valid/ready output slot,
// redirect request from downstream, and the halt indication.
interface ifetch_if;
    logic [7:0] imem_addr;
    logic [7:0] imem_instr;
    logic       out_valid;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic       out_ready;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       halted;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready,
        input  redirect_valid,
        input  redirect_pc,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready,
        output redirect_valid,
        output redirect_pc,
        input  halted
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, registers ROM data with its PC into a
// valid/ready slot. Optional jump predecode is enabled by JUMP_PREDECODE_EN.
module ifetch #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter int unsigned MEM_DEPTH = 32
) (
    input logic      i_clk,
    input logic      i_rst_n,
    ifetch_if.master bus
);
    localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);

    logic [7:0] r_pc;
    logic [7:0] r_instr;
    logic [7:0] r_out_pc;
    logic       r_valid;

    logic       w_in_range;
    logic       w_load;
    logic [7:0] w_next_pc;

    // 9-bit compare so MEM_DEPTH = 256 never reports end of program
    assign w_in_range = ({1'b0, r_pc} < DEPTH);
    assign w_load     = w_in_range && (!r_valid || bus.out_ready);

`ifdef JUMP_PREDECODE_EN
    always_comb begin
        w_next_pc = r_pc + 8'd1;
        if (bus.imem_instr[7:6] == 2'b11) begin
            w_next_pc = r_pc + 8'd1 + {{2{bus.imem_instr[5]}}, bus.imem_instr[5:0]};
        end
    end
`else
    assign w_next_pc = r_pc + 8'd1;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_out_pc <= '0;
        end else if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_instr  <= bus.imem_instr;
            r_out_pc <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= w_next_pc;
        end else if (r_valid && bus.out_ready) begin
            // accepted with no in-range PC left to fetch: slot drains
            r_valid <= 1'b0;
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.out_valid = r_valid;
    assign bus.out_instr = r_instr;
    assign bus.out_pc    = r_out_pc;
    assign bus.halted    = !w_in_range && !r_valid;
endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: three instances (MEM_DEPTH 9, 256, 32)
// share one clock, reset and ROM image.
module tb_ifetch;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [7:0] rom [256];

    always #5 clk = ~clk;

    ifetch_if a_if ();
    ifetch_if b_if ();
    ifetch_if c_if ();

    ifetch #(.RESET_PC(8'h00), .MEM_DEPTH(9))   u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(a_if));
    ifetch #(.RESET_PC(8'h00), .MEM_DEPTH(256)) u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(b_if));
    ifetch #(.RESET_PC(8'h00), .MEM_DEPTH(32))  u_c (.i_clk(clk), .i_rst_n(rst_n), .bus(c_if));

    assign a_if.imem_instr = rom[a_if.imem_addr];
    assign b_if.imem_instr = rom[b_if.imem_addr];
    assign c_if.imem_instr = rom[c_if.imem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] prog [9];
        logic [7:0] exp_c_addr;
        prog = '{8'h47, 8'h59, 8'h7D, 8'h71, 8'h5D, 8'h59, 8'h6D, 8'h71, 8'hC3};
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < 9; i++) rom[i] = prog[i];

        rst_n = 1'b0;
        a_if.out_ready = 1'b1; a_if.redirect_valid = 1'b0; a_if.redirect_pc = 8'h00;
        b_if.out_ready = 1'b1; b_if.redirect_valid = 1'b0; b_if.redirect_pc = 8'h00;
        c_if.out_ready = 1'b1; c_if.redirect_valid = 1'b0; c_if.redirect_pc = 8'h00;

        // reset state
        step();
        step();
        chk("rst_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst_instr", 32'(a_if.out_instr), 32'h00);
        chk("rst_pc",    32'(a_if.out_pc),    32'h00);
        chk("rst_addr",  32'(a_if.imem_addr), 32'h00);
        chk("rst_halt",  32'(a_if.halted),    32'd0);
        chk("rst_halt_b", 32'(b_if.halted),   32'd0);

        // sequential fetch, one per cycle
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            chk("seq_valid", 32'(a_if.out_valid), 32'd1);
            chk("seq_instr", 32'(a_if.out_instr), 32'(prog[i]));
            chk("seq_pc",    32'(a_if.out_pc),    32'(i));
            chk("seq_halt",  32'(a_if.halted),    32'd0);
            step();
        end
        chk("end_valid", 32'(a_if.out_valid), 32'd0);
        chk("end_halt",  32'(a_if.halted),    32'd1);
        step();
        chk("end_halt2", 32'(a_if.halted),    32'd1);

        // leave halt via redirect to 0, then backpressure at out_pc 2
        a_if.redirect_valid = 1'b1; a_if.redirect_pc = 8'h00;
        step();
        chk("rd0_valid", 32'(a_if.out_valid), 32'd0);
        chk("rd0_addr",  32'(a_if.imem_addr), 32'h00);
        chk("rd0_halt",  32'(a_if.halted),    32'd0);
        a_if.redirect_valid = 1'b0;
        step();
        chk("rd0_pc0", 32'(a_if.out_pc), 32'h00);
        step();
        chk("rd0_pc1", 32'(a_if.out_pc), 32'h01);
        step();
        chk("bp_pc2",  32'(a_if.out_pc),    32'h02);
        chk("bp_ins2", 32'(a_if.out_instr), 32'h7D);
        a_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", 32'(a_if.out_valid), 32'd1);
            chk("bp_hold_instr", 32'(a_if.out_instr), 32'h7D);
            chk("bp_hold_pc",    32'(a_if.out_pc),    32'h02);
            chk("bp_hold_addr",  32'(a_if.imem_addr), 32'h03);
        end
        a_if.out_ready = 1'b1;
        step();
        chk("bp_next_instr", 32'(a_if.out_instr), 32'h71);
        chk("bp_next_pc",    32'(a_if.out_pc),    32'h03);

        // redirect to 5 while out_pc = 1 is stalled
        a_if.redirect_valid = 1'b1; a_if.redirect_pc = 8'h00;
        step();
        a_if.redirect_valid = 1'b0;
        step();
        step();
        chk("rdr_pc1", 32'(a_if.out_pc), 32'h01);
        a_if.out_ready = 1'b0;
        a_if.redirect_valid = 1'b1; a_if.redirect_pc = 8'h05;
        step();
        chk("rdr_valid", 32'(a_if.out_valid), 32'd0);
        chk("rdr_addr",  32'(a_if.imem_addr), 32'h05);
        a_if.redirect_valid = 1'b0; a_if.out_ready = 1'b1;
        step();
        chk("rdr_v5",     32'(a_if.out_valid), 32'd1);
        chk("rdr_instr5", 32'(a_if.out_instr), 32'h59);
        chk("rdr_pc5",    32'(a_if.out_pc),    32'h05);

        // mid-operation reset beats a concurrent redirect
        rst_n = 1'b0;
        a_if.redirect_valid = 1'b1; a_if.redirect_pc = 8'h07;
        step();
        chk("mrst_valid", 32'(a_if.out_valid), 32'd0);
        chk("mrst_instr", 32'(a_if.out_instr), 32'h00);
        chk("mrst_pc",    32'(a_if.out_pc),    32'h00);
        chk("mrst_addr",  32'(a_if.imem_addr), 32'h00);
        rst_n = 1'b1; a_if.redirect_valid = 1'b0;
        step();
        chk("mrst_instr0", 32'(a_if.out_instr), 32'h47);
        chk("mrst_pc0",    32'(a_if.out_pc),    32'h00);

        // jump at PC 8: halts after acceptance on depth 9 either way
        a_if.redirect_valid = 1'b1; a_if.redirect_pc = 8'h08;
        c_if.redirect_valid = 1'b1; c_if.redirect_pc = 8'h08;
        step();
        a_if.redirect_valid = 1'b0;
        c_if.redirect_valid = 1'b0;
        step();
`ifdef JUMP_PREDECODE_EN
        exp_c_addr = 8'd12;
`else
        exp_c_addr = 8'd9;
`endif
        chk("jmp_instr", 32'(a_if.out_instr), 32'hC3);
        chk("jmp_pc",    32'(a_if.out_pc),    32'h08);
        chk("jmp_halt0", 32'(a_if.halted),    32'd0);
        chk("jmp_c_pc",   32'(c_if.out_pc),    32'h08);
        chk("jmp_c_addr", 32'(c_if.imem_addr), 32'(exp_c_addr));
        step();
        chk("jmp_valid", 32'(a_if.out_valid), 32'd0);
        chk("jmp_halt",  32'(a_if.halted),    32'd1);

        // wrap with MEM_DEPTH = 256
        b_if.redirect_valid = 1'b1; b_if.redirect_pc = 8'hFF;
        step();
        chk("wrap_halt_r", 32'(b_if.halted), 32'd0);
        b_if.redirect_valid = 1'b0;
        step();
        chk("wrap_pcff",  32'(b_if.out_pc),    32'hFF);
        chk("wrap_addr",  32'(b_if.imem_addr), 32'h00);
        chk("wrap_halt1", 32'(b_if.halted),    32'd0);
        step();
        chk("wrap_pc00",  32'(b_if.out_pc),    32'h00);
        chk("wrap_ins00", 32'(b_if.out_instr), 32'h47);
        chk("wrap_halt2", 32'(b_if.halted),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
